mealy_pattern_detector: RTL and testbench

Parametrised Mealy-type serial pattern detector: the next generation of the lab's fixed 6-state Mealy machine. Compares a one-bit input stream against a compile-time pattern of arbitrary width and asserts a same-cycle Mealy output on the completing bit. Supports runtime-selectable overlapping or non-overlapping detection, an input-valid qualifier and an optional saturating match counter. Sits directly behind a serial bit source; the `state` port is kept for debug and verification.

---
 rtl/mealy_pattern_detector.sv | 115 +++++++++++
 tb/tb_mealy_pattern_detector.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mealy_pattern_detector.sv
// Mealy serial pattern detector: KMP prefix-length state machine; match counter under MEALY_MATCH_CNT_EN.
// Latency: out is combinational on the completing bit; state/match_count update on the following edge.
// Backpressure: none; every in_valid cycle consumes exactly one bit.
module mealy_pattern_detector #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   CNT_W     = 8,
    localparam int                  SW        = $clog2(PATTERN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    output logic             out,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_count
);

    // Longest prefix of PATTERN that is a suffix of (prefix_s followed by b).
    // Capped below PATTERN_W: the full-length case is the match path, handled separately.
    function automatic int kmp_next(input int s, input logic b);
        int   best;
        int   j;
        logic ok;
        logic tbit;
        best = 0;
        for (int k = 1; k <= s + 1 && k < PATTERN_W; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                j    = s + 1 - k + i;
                tbit = (j == s) ? b : PATTERN[PATTERN_W-1-j];
                if (tbit != PATTERN[PATTERN_W-1-i]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Length of the longest proper border of PATTERN (restart point after an overlapping match).
    function automatic int border_len();
        int   best;
        logic ok;
        best = 0;
        for (int k = 1; k < PATTERN_W; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (PATTERN[PATTERN_W-1-i] != PATTERN[k-1-i]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    localparam int BORDER = border_len();
    localparam int LAST   = PATTERN_W - 1;

    // exp_vec[s] is the bit expected in state s; trans_tbl[{s,b}] is the no-match successor.
    logic [PATTERN_W-1:0] exp_vec;
    logic [SW-1:0]        trans_tbl [2*PATTERN_W];

    for (genvar g = 0; g < PATTERN_W; g++) begin : g_exp
        assign exp_vec[g] = PATTERN[PATTERN_W-1-g];
    end

    for (genvar g = 0; g < 2*PATTERN_W; g++) begin : g_trans
        localparam int NX = kmp_next(g / 2, 1'(g % 2));
        assign trans_tbl[g] = NX[SW-1:0];
    end

    logic [SW-1:0] state_nxt;
    logic          at_last;

    assign at_last = (state == LAST[SW-1:0]);
    assign out     = rst_n & in_valid & at_last & (in == exp_vec[state]);

    // Next-state selection: hold when idle, restart on a match, table lookup otherwise.
    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            if (out) begin
                state_nxt = overlap ? BORDER[SW-1:0] : '0;
            end else begin
                state_nxt = trans_tbl[{state, in}];
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= '0;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef MEALY_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating match counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Directed bench for mealy_pattern_detector (1011 pattern), plus a CNT_W=2 copy for saturation.
// Inputs change 1 ns after the rising edge; out is sampled on the falling edge, registers after the edge.
// Count expectations collapse to 0 when MEALY_MATCH_CNT_EN is not defined.
module tb_mealy_pattern_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_bit;
    logic       overlap;
    logic       out_a, out_b;
    logic [1:0] state_a, state_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_a   = 0;
    int exp_b   = 0;

    always #5 clk = ~clk;

    mealy_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
        .out(out_a), .state(state_a), .match_count(cnt_a)
    );

    mealy_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
        .out(out_b), .state(state_b), .match_count(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_exp(input int c);
`ifdef MEALY_MATCH_CNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    // One bit time; caller is positioned 1 ns after a rising edge.
    task automatic step(input string tag, input logic v, input logic b,
                        input logic eo, input int es);
        in_valid = v;
        in_bit   = b;
        @(negedge clk);
        check({tag, " out"}, 32'(out_a), 32'(eo));
        check({tag, " out_b"}, 32'(out_b), 32'(eo));
        @(posedge clk);
        #1;
        if (eo) begin
            if (exp_a < 255) exp_a++;
            if (exp_b < 3)   exp_b++;
        end
        check({tag, " state"}, 32'(state_a), 32'(es));
        check({tag, " cnt"}, 32'(cnt_a), 32'(cnt_exp(exp_a)));
        check({tag, " cnt_b"}, 32'(cnt_b), 32'(cnt_exp(exp_b)));
    endtask

    // One reset cycle driving a (possibly completing) bit; out must stay low throughout.
    task automatic do_reset(input string tag, input logic b);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        check({tag, " rst out"}, 32'(out_a), 32'(0));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        exp_a    = 0;
        exp_b    = 0;
        check({tag, " rst state"}, 32'(state_a), 32'(0));
        check({tag, " rst cnt"}, 32'(cnt_a), 32'(0));
    endtask

    logic [6:0] stream    = 7'b1011011;
    logic [6:0] out_ov    = 7'b0001001;
    logic [6:0] out_nov   = 7'b0001000;
    int         st_ov [7] = '{1, 2, 3, 1, 2, 3, 1};
    int         st_nov[7] = '{1, 2, 3, 0, 0, 1, 1};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        overlap  = 1'b1;
        @(posedge clk);
        #1;

        // Reset then idle zeros.
        do_reset("init", 1'b0);
        for (int i = 0; i < 3; i++) step("idle", 1'b1, 1'b0, 1'b0, 0);

        // Overlapping detection.
        do_reset("ov", 1'b0);
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) step("ov", 1'b1, stream[6-i], out_ov[6-i], st_ov[i]);
        check("ov total", 32'(cnt_a), 32'(cnt_exp(2)));

        // Non-overlapping detection.
        do_reset("nov", 1'b0);
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) step("nov", 1'b1, stream[6-i], out_nov[6-i], st_nov[i]);
        check("nov total", 32'(cnt_a), 32'(cnt_exp(1)));

        // Valid gaps: idle cycles carry in=1 so a leaked consume would show.
        do_reset("gap", 1'b0);
        overlap = 1'b1;
        step("gap", 1'b1, 1'b1, 1'b0, 1);
        step("gap", 1'b0, 1'b1, 1'b0, 1);
        step("gap", 1'b1, 1'b0, 1'b0, 2);
        step("gap", 1'b0, 1'b1, 1'b0, 2);
        step("gap", 1'b1, 1'b1, 1'b0, 3);
        step("gap", 1'b0, 1'b1, 1'b0, 3);
        step("gap", 1'b1, 1'b1, 1'b1, 1);

        // Mid-pattern reset that coincides with a completing bit: reset wins.
        do_reset("mid", 1'b0);
        step("mid", 1'b1, 1'b1, 1'b0, 1);
        step("mid", 1'b1, 1'b0, 1'b0, 2);
        step("mid", 1'b1, 1'b1, 1'b0, 3);
        do_reset("mid", 1'b1);
        step("mid after", 1'b1, 1'b1, 1'b0, 1);

        // Saturation: five overlapping matches; the 2-bit counter goes 1,2,3,3,3.
        do_reset("sat", 1'b0);
        overlap = 1'b1;
        step("sat", 1'b1, 1'b1, 1'b0, 1);
        step("sat", 1'b1, 1'b0, 1'b0, 2);
        step("sat", 1'b1, 1'b1, 1'b0, 3);
        step("sat", 1'b1, 1'b1, 1'b1, 1);
        check("sat m1", 32'(cnt_b), 32'(cnt_exp(1)));
        for (int m = 2; m <= 5; m++) begin
            step("sat", 1'b1, 1'b0, 1'b0, 2);
            step("sat", 1'b1, 1'b1, 1'b0, 3);
            step("sat", 1'b1, 1'b1, 1'b1, 1);
            check("sat mN", 32'(cnt_b), 32'(cnt_exp(m > 3 ? 3 : m)));
        end
        check("sat wide", 32'(cnt_a), 32'(cnt_exp(5)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
